div_unit: RTL and testbench

- Iterative restoring divider. It is the inverse-direction companion to the single-cycle ALU multiply.
- It sits beside the ALU in the EX stage. The hazard/stall logic holds the pipeline while busy_o is high.
- One quotient bit is resolved per clock.
- A start/busy/done handshake lets the control unit launch a divide and capture the quotient and remainder.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder can exceed WIDTH bits, so the trial runs one bit wider.
    assign rem_shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial       = rem_shifted - {1'b0, divisor_i};

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div0_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] quot_fix, rmd_fix;
    logic             accept;

    assign accept = start_i && (state_q == StIdle || state_q == StDone);

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_rmd_q;

    assign dvd_mag  = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
    assign dsr_mag  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
    assign quot_fix = neg_quot_q ? -step_quo : step_quo;
    assign rmd_fix  = neg_rmd_q  ? -step_rem : step_rem;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            neg_quot_q <= 1'b0;
            neg_rmd_q  <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            neg_rmd_q  <= dividend_i[WIDTH-1];
        end
    end
`else
    assign dvd_mag  = dividend_i;
    assign dsr_mag  = divisor_i;
    assign quot_fix = step_quo;
    assign rmd_fix  = step_rem;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        div0_d  = div0_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    if (divisor_i == '0) begin
                        state_d = StDone;
                        quot_d  = {WIDTH{1'b1}};
                        rmd_d   = dividend_i;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = dvd_mag;
                        dsr_d   = dsr_mag;
                    end
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                // This edge performs the final (WIDTH-th) step.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StDone;
                    quot_d  = quot_fix;
                    rmd_d   = rmd_fix;
                    div0_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign quotient_o  = quot_q;
    assign remainder_o = rmd_q;
    assign div0_o      = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH = 32).
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div0;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div0_o      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Presents operands on the falling edge; returns #1 after the accepting edge T0.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    // k = index of the edge after which done is high (0 = right after T0).
    task automatic wait_done(input int k0, output int k, output int busy_cycles);
        k = k0;
        busy_cycles = 0;
        while (!done && k < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    int k, bc;

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check_eq("reset_busy", W'(busy), 32'd0);
        check_eq("reset_done", W'(done), 32'd0);
        check_eq("reset_quot", quotient, 32'd0);
        check_eq("reset_rem", remainder, 32'd0);
        check_eq("reset_div0", W'(div0), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 100 / 7 = 14 r 2, done after edge T32
        launch(32'd100, 32'd7);
        wait_done(0, k, bc);
        check_eq("basic_done", W'(done), 32'd1);
        check_eq("basic_lat", W'(k), 32'd32);
        check_eq("basic_busy", W'(bc), 32'd32);
        check_eq("basic_quot", quotient, 32'd14);
        check_eq("basic_rem", remainder, 32'd2);
        check_eq("basic_div0", W'(div0), 32'd0);
        @(posedge clk);
        #1;
        check_eq("basic_pulse", W'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_quot", quotient, 32'd14);
        check_eq("hold_rem", remainder, 32'd2);

        // divide by zero: straight to DONE
        launch(32'h0000_1234, 32'd0);
        wait_done(0, k, bc);
        check_eq("div0_done", W'(done), 32'd1);
        check_eq("div0_lat", W'(k), 32'd0);
        check_eq("div0_busy", W'(bc), 32'd0);
        check_eq("div0_quot", quotient, 32'hFFFF_FFFF);
        check_eq("div0_rem", remainder, 32'h0000_1234);
        check_eq("div0_flag", W'(div0), 32'd1);

        // start during RUN is ignored
        launch(32'hFFFF_FFFF, 32'h10);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("ign_busy", W'(busy), 32'd1);
        wait_done(10, k, bc);
        check_eq("ign_lat", W'(k), 32'd32);
`ifdef DIV_SIGNED_EN
        check_eq("ign_quot", quotient, 32'd0);
        check_eq("ign_rem", remainder, 32'hFFFF_FFFF);
`else
        check_eq("ign_quot", quotient, 32'h0FFF_FFFF);
        check_eq("ign_rem", remainder, 32'h0000_000F);
`endif
        check_eq("ign_div0", W'(div0), 32'd0);

        // back-to-back launch from the DONE cycle
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'd77;
        check_eq("b2b_busy", W'(busy), 32'd1);
        wait_done(0, k, bc);
        check_eq("b2b_lat", W'(k), 32'd32);
        check_eq("b2b_quot", quotient, 32'd3);
        check_eq("b2b_rem", remainder, 32'd0);

        // asynchronous reset mid-operation
        launch(32'd50, 32'd5);
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_busy", W'(busy), 32'd0);
        check_eq("arst_done", W'(done), 32'd0);
        check_eq("arst_quot", quotient, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        launch(32'd50, 32'd5);
        wait_done(0, k, bc);
        check_eq("post_lat", W'(k), 32'd32);
        check_eq("post_quot", quotient, 32'd10);
        check_eq("post_rem", remainder, 32'd0);

`ifdef DIV_SIGNED_EN
        launch(-32'sd7, 32'd2);
        wait_done(0, k, bc);
        check_eq("s_m7_2_quot", quotient, 32'hFFFF_FFFD);
        check_eq("s_m7_2_rem", remainder, 32'hFFFF_FFFF);
        launch(32'd7, -32'sd2);
        wait_done(0, k, bc);
        check_eq("s_7_m2_quot", quotient, 32'hFFFF_FFFD);
        check_eq("s_7_m2_rem", remainder, 32'd1);
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, k, bc);
        check_eq("s_ovf_lat", W'(k), 32'd32);
        check_eq("s_ovf_quot", quotient, 32'h8000_0000);
        check_eq("s_ovf_rem", remainder, 32'd0);
        check_eq("s_ovf_div0", W'(div0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
